block_mem_ctrl: RTL and testbench
=================================

// Module: block_mem_ctrl
// PURPOSE
// - Backing-memory stage directly downstream of the data cache: services whole-block (32-bit) loads and stores.
// - Uses a 4-phase req/done handshake in place of the cache's ad-hoc store_ack scheme.
// - Models a fixed access LATENCY and holds the result until the cache drops its request.
// - Owns the block storage array (one 32-bit block = BL_NUM_BYTES=4 bytes).
// PARAMETERS
// - BLOCK_W  32  block width in bits (one cache block)
// - ADDR_W   10  block-index width; memory depth = 2**ADDR_W blocks
// - LATENCY  2   cycles from request acceptance to done; legal range 1..15
// PORTS
// - clk            in   1       single clock; all state updates on posedge
// - rst_n          in   1       asynchronous, active-low reset
// - addr_in        in   16      byte address; block index = addr_in[ADDR_W+1:2]; addr_in[1:0] ignored
// - wdata_in       in   BLOCK_W block to store; sampled at acceptance edge
// - mem_load_req   in   1       cache requests block read; level, held until load_completed seen
// - mem_store_req  in   1       cache requests block write; level, held until store_completed seen
// - rdata_out      out  BLOCK_W loaded block; valid while load_completed=1
// - load_completed out  1       load done; held until mem_load_req=0
// - store_completed out 1       store done; held until mem_store_req=0
// - busy           out  1       high in any state other than IDLE
// - addr_err       out  1       1-cycle pulse at acceptance if addr_in[15:ADDR_W+2] != 0 (request still served, index truncated)
// BEHAVIOUR
// - Reset (async assert, sync deassert at top level): state=IDLE, cnt=0, rdata_out=0.
//   Reset also clears load_completed, store_completed, busy and addr_err.
//   Array contents are not reset and are retained across reset.
// - FSM states: IDLE, WAIT, DONE.
// - IDLE: at an edge with mem_store_req|mem_load_req=1, latch op, index and wdata.
//   Load cnt=LATENCY-1, go to WAIT (acceptance edge E0).
// - Simultaneous load+store in IDLE: store wins; the load is accepted after the store's handshake closes.
// - WAIT: cnt decrements each edge. At the edge where cnt==0:
//   - store: array[idx] <= wdata.
//   - load: rdata_out <= array[idx].
//   - go to DONE and assert the matching *_completed.
//   Net effect: *_completed first high after edge E0+LATENCY.
// - DONE: hold *_completed and rdata_out stable.
//   When the latched op's req is seen low: deassert *_completed, return to IDLE. Minimum 1 cycle in DONE.
// - Request inputs are not re-sampled during WAIT. A req dropped mid-WAIT still completes.
//   DONE then exits on the first edge.
// - Back-to-back: a new request is accepted no earlier than the edge after DONE->IDLE (1 idle cycle minimum).
// - Load and store to the same index: a load issued after a store's completion returns the new data.
// - rdata_out keeps its last value outside DONE.
// - Reset mid-WAIT: the pending store is dropped (array untouched); completed flags low immediately.
// - cnt is 4 bits; LATENCY outside 1..15 is an elaboration error ($fatal in an initial check).
// STRUCTURE
// - Shared package mem_pkg: typedef enum {IDLE, WAIT, DONE} mem_state_t; typedef enum {OP_LOAD, OP_STORE} mem_op_t.
//   mem_pkg also holds localparams BLOCK_W=32 and BL_NUM_BYTES=4 (also used by cache).
// - Sub-module block_ram: synchronous single-port BLOCK_W x 2**ADDR_W array with we, idx, wdata, rdata.
//   block_ram has no reset; read data is registered.
// - Top: FSM, latency counter, op/index/wdata latches, output registers.
// TESTING
// - Reset: rst_n=0 mid-sim -> all outputs 0 within same cycle; after release busy=0.
// - Store: addr 0x0008, wdata 0xDEAD0100, LATENCY=2 -> store_completed high after E0+2.
//   store_completed stays high until req drops; the next cycle it is low.
// - Load-after-store: load 0x0008 -> load_completed after E0+2 with rdata_out=0xDEAD0100.
//   Load 0x000A returns the same block.
// - Simultaneous load+store, same index, wdata 0x12345678: store completes first.
//   The load then returns 0x12345678.
// - Handshake: hold mem_load_req 5 cycles past done -> load_completed and rdata_out stable all 5 cycles.
//   Drop req mid-WAIT -> completed pulses for exactly 1 cycle.
// - Reset mid-WAIT of a store to 0x0010 over old 0xAAAA5555 -> subsequent load returns 0xAAAA5555.
//   addr 0x1000 with ADDR_W=10 -> addr_err pulse; the access wraps to index 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the data cache and its backing memory.
// Block geometry is common to both sides of the req/done interface.
package mem_pkg;

  localparam int BLOCK_W      = 32;
  localparam int BL_NUM_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } mem_state_t;

  typedef enum logic {
    OP_LOAD,
    OP_STORE
  } mem_op_t;

endpackage

// File: rtl/block_ram.sv
// Single-port block array with a registered read port.
// Contents have no reset and survive a controller reset.
module block_ram #(
  parameter int W  = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we)
      mem[idx] <= wdata;
    rdata <= mem[idx];
  end

endmodule

// File: rtl/block_mem_ctrl.sv
// Backing-memory stage below the data cache: whole-block loads
// and stores over a 4-phase req/done handshake with fixed latency.
module block_mem_ctrl #(
  parameter int BLOCK_W = 32,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        addr_in,
  input  logic [BLOCK_W-1:0] wdata_in,
  input  logic               mem_load_req,
  input  logic               mem_store_req,
  output logic [BLOCK_W-1:0] rdata_out,
  output logic               load_completed,
  output logic               store_completed,
  output logic               busy,
  output logic               addr_err
);

  import mem_pkg::*;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $fatal(1, "block_mem_ctrl: LATENCY must be 1..15");
  end

  mem_state_t         state;
  mem_op_t            op_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [BLOCK_W-1:0] wdata_q;
  logic [3:0]         cnt;

  logic [ADDR_W-1:0]  addr_idx;
  logic               addr_hi;
  logic [ADDR_W-1:0]  ram_idx;
  logic               ram_we;
  logic [BLOCK_W-1:0] ram_rdata;
  logic               op_req;
  logic               unused_lsb;

  assign addr_idx   = addr_in[ADDR_W+1:2];
  assign addr_hi    = |addr_in[15:ADDR_W+2];
  assign unused_lsb = ^addr_in[1:0];

  // In IDLE the array is addressed straight from the request so the
  // registered read is already valid by the end of a 1-cycle latency.
  assign ram_idx = (state == IDLE) ? addr_idx : idx_q;
  assign ram_we  = (state == WAIT) && (cnt == 4'd0)
                && (op_q == OP_STORE);
  assign op_req  = (op_q == OP_STORE) ? mem_store_req
                                      : mem_load_req;

  block_ram #(
    .W  (BLOCK_W),
    .AW (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .idx   (ram_idx),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      op_q            <= OP_LOAD;
      idx_q           <= '0;
      wdata_q         <= '0;
      cnt             <= '0;
      rdata_out       <= '0;
      load_completed  <= 1'b0;
      store_completed <= 1'b0;
      busy            <= 1'b0;
      addr_err        <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem_store_req || mem_load_req) begin
            op_q     <= mem_store_req ? OP_STORE : OP_LOAD;
            idx_q    <= addr_idx;
            wdata_q  <= wdata_in;
            cnt      <= 4'(LATENCY - 1);
            addr_err <= addr_hi;
            busy     <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= DONE;
            if (op_q == OP_STORE) begin
              store_completed <= 1'b1;
            end else begin
              load_completed <= 1'b1;
              rdata_out      <= ram_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (!op_req) begin
            load_completed  <= 1'b0;
            store_completed <= 1'b0;
            busy            <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_mem_ctrl.sv
// Directed and randomized checks of block_mem_ctrl against
// a simple array model of the block storage.
module tb_block_mem_ctrl;

  localparam int LAT = 2;
  localparam int AW  = 10;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr_in;
  logic [31:0] wdata_in;
  logic        mem_load_req;
  logic        mem_store_req;
  logic [31:0] rdata_out;
  logic        load_completed;
  logic        store_completed;
  logic        busy;
  logic        addr_err;

  int checks;
  int errors;

  logic [31:0] mm [2**AW];
  bit          mv [2**AW];

  block_mem_ctrl #(
    .BLOCK_W (32),
    .ADDR_W  (AW),
    .LATENCY (LAT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .addr_in         (addr_in),
    .wdata_in        (wdata_in),
    .mem_load_req    (mem_load_req),
    .mem_store_req   (mem_store_req),
    .rdata_out       (rdata_out),
    .load_completed  (load_completed),
    .store_completed (store_completed),
    .busy            (busy),
    .addr_err        (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h",
             tag, obs, exp);
    end
  endtask

  // One full handshake; the model is updated on store completion.
  task automatic access(input bit is_st,
                        input logic [15:0] a,
                        input logic [31:0] d,
                        input int hold,
                        input bit drop_early);
    int          n;
    bit          seen;
    int          idx;
    logic [31:0] exp_rd;
    logic [31:0] got;
    idx  = int'(a[11:2]);
    n    = 0;
    seen = 1'b0;
    @(negedge clk);
    addr_in  = a;
    wdata_in = d;
    if (is_st) mem_store_req = 1'b1;
    else       mem_load_req  = 1'b1;
    while (n < 40 && !seen) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("addr_err", 32'(addr_err), 32'(|a[15:12]));
        chk("busy_wait", 32'(busy), 32'd1);
        if (drop_early) begin
          mem_store_req = 1'b0;
          mem_load_req  = 1'b0;
        end
      end
      seen = is_st ? store_completed : load_completed;
    end
    chk(is_st ? "st_latency" : "ld_latency", 32'(n), 32'(LAT + 1));
    chk("other_done", 32'(is_st ? load_completed : store_completed), 32'd0);
    if (is_st) begin
      mm[idx] = d;
      mv[idx] = 1'b1;
    end else if (mv[idx]) begin
      chk("rdata", rdata_out, mm[idx]);
    end
    got    = rdata_out;
    exp_rd = got;
    if (!drop_early) begin
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        chk("done_hold", 32'(is_st ? store_completed : load_completed), 32'd1);
        if (!is_st) chk("rdata_hold", rdata_out, exp_rd);
      end
      mem_store_req = 1'b0;
      mem_load_req  = 1'b0;
    end
    @(negedge clk);
    chk("done_drop", 32'(is_st ? store_completed : load_completed), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    addr_in       = '0;
    wdata_in      = '0;
    mem_load_req  = 1'b0;
    mem_store_req = 1'b0;
    for (int i = 0; i < 2**AW; i++) mv[i] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", rdata_out, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", 32'({load_completed, store_completed, addr_err}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    access(1'b1, 16'h0008, 32'hDEAD0100, 0, 1'b0);
    access(1'b0, 16'h0008, 32'h0, 0, 1'b0);
    access(1'b0, 16'h000A, 32'h0, 0, 1'b0);
    access(1'b0, 16'h0008, 32'h0, 5, 1'b0);
    access(1'b0, 16'h0009, 32'h0, 0, 1'b1);
    access(1'b1, 16'h0004, 32'h0BAD_F00D, 0, 1'b1);
    access(1'b0, 16'h0004, 32'h0, 1, 1'b0);

    // Simultaneous load and store to one index: store first.
    @(negedge clk);
    addr_in       = 16'h000C;
    wdata_in      = 32'h12345678;
    mem_store_req = 1'b1;
    mem_load_req  = 1'b1;
    n = 0;
    while (n < 40 && !store_completed && !load_completed) begin
      @(negedge clk);
      n++;
    end
    chk("sim_st_first", 32'({store_completed, load_completed}), 32'd2);
    chk("sim_st_lat", 32'(n), 32'(LAT + 1));
    mem_store_req = 1'b0;
    n = 0;
    while (n < 40 && !load_completed) begin
      @(negedge clk);
      n++;
    end
    chk("sim_ld_done", 32'(load_completed), 32'd1);
    chk("sim_ld_data", rdata_out, 32'h12345678);
    mm[3] = 32'h12345678;
    mv[3] = 1'b1;
    mem_load_req = 1'b0;
    @(negedge clk);
    chk("sim_ld_drop", 32'(load_completed), 32'd0);

    // Reset asserted while outputs are active.
    access(1'b1, 16'h0010, 32'hAAAA5555, 0, 1'b0);
    @(negedge clk);
    addr_in      = 16'h0010;
    mem_load_req = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    chk("pre_rst_done", 32'(load_completed), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rdata", rdata_out, 32'd0);
    chk("arst_flags", 32'({load_completed, busy}), 32'd0);
    mem_load_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a store drops it.
    @(negedge clk);
    addr_in       = 16'h0010;
    wdata_in      = 32'h0000FFFF;
    mem_store_req = 1'b1;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst", 32'({store_completed, busy}), 32'd0);
    mem_store_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    access(1'b0, 16'h0010, 32'h0, 0, 1'b0);

    // Out-of-range address wraps to index 0.
    access(1'b1, 16'h1000, 32'hC0FFEE00, 0, 1'b0);
    access(1'b0, 16'h0000, 32'h0, 0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      logic [15:0] a;
      a = 16'({$urandom_range(0, 7), 2'($urandom)});
      if ($urandom_range(0, 5) == 0) a[15:12] = 4'($urandom);
      access(1'($urandom), a, $urandom,
             int'($urandom_range(0, 3)),
             $urandom_range(0, 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
